// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_unit: flag register, branch evaluation, 1-entry redirect   |
// | buffer; optional 2-bit counter predictor under BRANCH_PRED_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter int ADDR_W     = 32,
  parameter int N_FLAGS    = 4,
  parameter int SEL_W      = 2,
  parameter int PRED_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flagWe,
  input  logic [N_FLAGS-1:0] aluFlags,
  input  logic              brValid,
  output logic              brReady,
  input  logic              brUncond,
  input  logic [SEL_W-1:0]  brFlagSel,
  input  logic              brNotEq,
  input  logic [ADDR_W-1:0] brPc,
  input  logic [ADDR_W-1:0] brTarget,
  output logic              predTaken,
  output logic              resValid,
  input  logic              resReady,
  output logic              resTaken,
  output logic [ADDR_W-1:0] resTarget,
  output logic              resFlush,
  output logic [N_FLAGS-1:0] flagsOut
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N_FLAGS-1:0]  flags_q, flags_d;
  logic                res_taken_q, res_taken_d;
  logic [ADDR_W-1:0]   res_target_q, res_target_d;
  logic                res_flush_q, res_flush_d;

  logic [N_FLAGS-1:0]  eff_flags;
  logic [2**SEL_W-1:0] flags_ext;
  logic                cond;
  logic                taken;
  logic [ADDR_W-1:0]   target;
  logic                accept;
  logic                pop;
  logic                pred;

  // Zero-extending to the full select range makes out-of-range selects read 0.
  always_comb begin
    eff_flags              = flagWe ? aluFlags : flags_q;
    flags_ext              = '0;
    flags_ext[N_FLAGS-1:0] = eff_flags;
    cond                   = flags_ext[brFlagSel];
    taken                  = brUncond | (cond ^ brNotEq);
    target                 = taken ? brTarget : brPc + ADDR_W'(4);
    flags_d                = flagWe ? aluFlags : flags_q;
  end

`ifdef BRANCH_PRED_EN
  localparam int N_PRED = 2**PRED_IDX_W;

  logic [1:0]            ctr_q [N_PRED];
  logic [1:0]            ctr_d [N_PRED];
  logic [PRED_IDX_W-1:0] pred_idx;

  assign pred_idx = brPc[PRED_IDX_W+1:2];
  assign pred     = ctr_q[pred_idx][1];

  always_comb begin
    ctr_d = ctr_q;
    if (accept) begin
      if (taken && (ctr_q[pred_idx] != 2'd3)) begin
        ctr_d[pred_idx] = ctr_q[pred_idx] + 2'd1;
      end else if (!taken && (ctr_q[pred_idx] != 2'd0)) begin
        ctr_d[pred_idx] = ctr_q[pred_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PRED; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end
`else
  assign pred = 1'b0;
`endif

  assign brReady = (state_q == ST_EMPTY) | resReady;
  assign accept  = brValid & brReady;
  assign pop     = (state_q == ST_FULL) & resReady;

  always_comb begin
    state_d      = state_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    res_flush_d  = res_flush_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_FULL;
          res_taken_d  = taken;
          res_target_d = target;
          res_flush_d  = taken ^ pred;
        end
      end
      ST_FULL: begin
        // A pop with a same-cycle accept refills without a bubble.
        if (accept) begin
          res_taken_d  = taken;
          res_target_d = target;
          res_flush_d  = taken ^ pred;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      flags_q      <= '0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
      res_flush_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      res_flush_q  <= res_flush_d;
    end
  end

  assign predTaken = pred;
  assign resValid  = (state_q == ST_FULL);
  assign resTaken  = res_taken_q;
  assign resTarget = res_target_q;
  assign resFlush  = res_flush_q;
  assign flagsOut  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_resolve_unit: vector table, directed corners and random run    |
// | against a behavioural model of branch_resolve_unit. Rev 1.0              |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_unit;

  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flagWe;
  logic [3:0]  aluFlags;
  logic        brValid, brUncond, brNotEq, resReady;
  logic [1:0]  brFlagSel;
  logic [31:0] brPc, brTarget;
  logic        brReady, predTaken, resValid, resTaken, resFlush;
  logic [31:0] resTarget;
  logic [3:0]  flagsOut;

  logic        brReady3, predTaken3, resValid3, resTaken3, resFlush3;
  logic [31:0] resTarget3;
  logic [2:0]  flagsOut3;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [3:0]  m_flags;
  logic        m_valid, m_taken, m_flush;
  logic [31:0] m_tgt;
  int          m_ctr [16];

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .flagWe(flagWe), .aluFlags(aluFlags),
    .brValid(brValid), .brReady(brReady), .brUncond(brUncond),
    .brFlagSel(brFlagSel), .brNotEq(brNotEq), .brPc(brPc), .brTarget(brTarget),
    .predTaken(predTaken), .resValid(resValid), .resReady(resReady),
    .resTaken(resTaken), .resTarget(resTarget), .resFlush(resFlush),
    .flagsOut(flagsOut)
  );

  branch_resolve_unit #(.N_FLAGS(3)) dut3 (
    .clk(clk), .rst(rst), .flagWe(flagWe), .aluFlags(aluFlags[2:0]),
    .brValid(brValid), .brReady(brReady3), .brUncond(brUncond),
    .brFlagSel(brFlagSel), .brNotEq(brNotEq), .brPc(brPc), .brTarget(brTarget),
    .predTaken(predTaken3), .resValid(resValid3), .resReady(resReady),
    .resTaken(resTaken3), .resTarget(resTarget3), .resFlush(resFlush3),
    .flagsOut(flagsOut3)
  );

  typedef struct {
    logic [3:0]  pre;
    logic        we;
    logic [3:0]  alu;
    logic        unc;
    logic [1:0]  sel;
    logic        neq;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exp_taken;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_flush = 1'b0;
    m_tgt   = '0;
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
  endtask

  task automatic idle();
    flagWe = 0; aluFlags = 0; brValid = 0; brUncond = 0; brFlagSel = 0;
    brNotEq = 0; brPc = 0; brTarget = 0; resReady = 1;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    logic [3:0]  eff;
    logic        cond, tk, acc, pt, exp_rdy;
    int          idx;
    #2;
    eff  = flagWe ? aluFlags : m_flags;
    cond = (int'(brFlagSel) < NF) ? eff[brFlagSel] : 1'b0;
    tk   = brUncond || (cond != brNotEq);
    idx  = int'((brPc / 4) % 16);
`ifdef BRANCH_PRED_EN
    pt = (m_ctr[idx] >= 2);
`else
    pt = 1'b0;
`endif
    exp_rdy = !m_valid || resReady;
    acc     = brValid && exp_rdy;
    chk("brReady", {31'd0, brReady}, {31'd0, exp_rdy});
    chk("predTaken", {31'd0, predTaken}, {31'd0, pt});
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1'b1;
      m_taken = tk;
      m_tgt   = tk ? brTarget : brPc + 32'd4;
      m_flush = tk ^ pt;
      if (tk) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
      else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
    end else if (m_valid && resReady) begin
      m_valid = 1'b0;
    end
    if (flagWe) m_flags = aluFlags;
    chk("resValid", {31'd0, resValid}, {31'd0, m_valid});
    chk("flagsOut", {28'd0, flagsOut}, {28'd0, m_flags});
    if (m_valid) begin
      chk("resTaken", {31'd0, resTaken}, {31'd0, m_taken});
      chk("resTarget", resTarget, m_tgt);
      chk("resFlush", {31'd0, resFlush}, {31'd0, m_flush});
    end
  endtask

  logic [2:0] exp_pt;
  logic [2:0] exp_fl;

  initial begin
    vecs[0] = '{4'b0010, 0, 4'b0000, 0, 2'd1, 0, 32'h100, 32'h200, 1, 32'h200};
    vecs[1] = '{4'b0010, 1, 4'b0000, 0, 2'd1, 0, 32'h100, 32'h200, 0, 32'h104};
    vecs[2] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 32'h120, 32'h080, 1, 32'h080};
    vecs[3] = '{4'b0000, 0, 4'b0000, 1, 2'd2, 0, 32'h130, 32'h500, 1, 32'h500};
    vecs[4] = '{4'b1000, 0, 4'b0000, 0, 2'd3, 0, 32'h140, 32'h600, 1, 32'h600};
    vecs[5] = '{4'b1000, 0, 4'b0000, 0, 2'd3, 1, 32'h144, 32'h600, 0, 32'h148};
    vecs[6] = '{4'b0000, 0, 4'b0000, 0, 2'd1, 0, 32'hFFFFFFFC, 32'h10, 0, 32'h0};
    vecs[7] = '{4'b0000, 1, 4'b0100, 0, 2'd2, 0, 32'h150, 32'h700, 1, 32'h700};

    idle();
    rst = 1'b0;
    model_reset();
    #12;
    chk("rst_resValid", {31'd0, resValid}, 32'd0);
    chk("rst_resTaken", {31'd0, resTaken}, 32'd0);
    chk("rst_resTarget", resTarget, 32'd0);
    chk("rst_resFlush", {31'd0, resFlush}, 32'd0);
    chk("rst_flagsOut", {28'd0, flagsOut}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: preset flag register, then one branch from EMPTY.
    for (int v = 0; v < 8; v++) begin
      idle();
      flagWe = 1; aluFlags = vecs[v].pre;
      cycle();
      idle();
      flagWe = vecs[v].we; aluFlags = vecs[v].alu; brValid = 1;
      brUncond = vecs[v].unc; brFlagSel = vecs[v].sel; brNotEq = vecs[v].neq;
      brPc = vecs[v].pc; brTarget = vecs[v].tgt; resReady = 0;
      cycle();
      chk($sformatf("vec%0d_valid", v), {31'd0, resValid}, 32'd1);
      chk($sformatf("vec%0d_taken", v), {31'd0, resTaken}, {31'd0, vecs[v].exp_taken});
      chk($sformatf("vec%0d_target", v), resTarget, vecs[v].exp_tgt);
      idle();
      cycle();
    end

    // Backpressure: hold FULL for 3 cycles, then back-to-back refill.
    idle();
    brValid = 1; brUncond = 1; brPc = 32'h200; brTarget = 32'h800; resReady = 0;
    cycle();
    brPc = 32'h204; brTarget = 32'h900;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_brReady", {31'd0, brReady}, 32'd0);
      chk("bp_hold_target", resTarget, 32'h800);
    end
    resReady = 1;
    cycle();
    chk("bp_refill_valid", {31'd0, resValid}, 32'd1);
    chk("bp_refill_target", resTarget, 32'h900);
    idle();
    cycle();

    // Out-of-range select on a 3-flag instance.
    idle();
    flagWe = 1; aluFlags = 4'b1111;
    cycle();
    idle();
    brValid = 1; brFlagSel = 2'd3; brPc = 32'h300; brTarget = 32'h400; resReady = 0;
    cycle();
    chk("nf3_valid", {31'd0, resValid3}, 32'd1);
    chk("nf3_taken", {31'd0, resTaken3}, 32'd0);
    chk("nf3_target", resTarget3, 32'h304);

    // Asynchronous reset while FULL with non-zero flags.
    idle();
    flagWe = 1; aluFlags = 4'b1010; brValid = 1; brUncond = 1;
    brPc = 32'h10; brTarget = 32'h20; resReady = 0;
    cycle();
    idle();
    resReady = 0;
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_resValid", {31'd0, resValid}, 32'd0);
    chk("mid_rst_flagsOut", {28'd0, flagsOut}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_brReady", {31'd0, brReady}, 32'd1);
    @(posedge clk);
    #1;

    // Same PC taken three times: predictor warm-up.
`ifdef BRANCH_PRED_EN
    exp_pt = 3'b110;
    exp_fl = 3'b001;
`else
    exp_pt = 3'b000;
    exp_fl = 3'b111;
`endif
    for (int i = 0; i < 3; i++) begin
      idle();
      brValid = 1; brFlagSel = 2'd1; brNotEq = 1; brPc = 32'h40; brTarget = 32'h80;
      #1;
      chk($sformatf("pred%0d_predTaken", i), {31'd0, predTaken}, {31'd0, exp_pt[i]});
      cycle();
      chk($sformatf("pred%0d_resFlush", i), {31'd0, resFlush}, {31'd0, exp_fl[i]});
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      flagWe    = ($urandom_range(0, 3) == 0);
      aluFlags  = 4'($urandom);
      brValid   = ($urandom_range(0, 2) != 0);
      brUncond  = ($urandom_range(0, 4) == 0);
      brFlagSel = 2'($urandom);
      brNotEq   = 1'($urandom);
      brPc      = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom_range(0, 63), 2'b00};
      brTarget  = $urandom;
      resReady  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
